// File: rtl/align_fifo_reader_pkg.sv
// rtl/align_fifo_reader_pkg.sv - shared read-side state encodings and skid depth
package align_fifo_reader_pkg;

    localparam logic [1:0] ALIGN_RD_IDLE  = 2'd0;
    localparam logic [1:0] ALIGN_RD_RUN   = 2'd1;
    localparam logic [1:0] ALIGN_RD_DRAIN = 2'd2;
    localparam logic [1:0] ALIGN_RD_DONE  = 2'd3;

    // Skid depth is shared with the write-side blocks of the alignment lane.
    localparam int ALIGN_SKID_D = 2;

endpackage

// File: rtl/align_fifo_reader_skid_buf.sv
// rtl/align_fifo_reader_skid_buf.sv - 2-entry skid buffer between FIFO read data and the array stream
module align_skid_buf
    import align_fifo_reader_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         m_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [0:ALIGN_SKID_D-1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         bypass;
    logic         push;
    logic         pop;

    // An empty buffer presents the arriving FIFO word directly, so a ready
    // array sees one word per cycle; it is stored only if the array stalls.
    assign bypass  = wr_en && (occ == 2'd0);
    assign m_valid = (occ != 2'd0) || wr_en;
    assign m_data  = (occ != 2'd0) ? mem[rd_ptr] : (wr_en ? wr_data : '0);
    assign push    = wr_en && !(bypass && m_ready);
    assign pop     = (occ != 2'd0) && m_ready;

    // Storage write at the tail; contents are qualified by occ so need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep occ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/align_fifo_reader.sv
// rtl/align_fifo_reader.sv - alignment FIFO read controller; optional ALIGN_READER_STALL_CNT_EN stall counter
module align_fifo_reader
    import align_fifo_reader_pkg::*;
#(
    parameter int W     = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_re,
    input  logic [W-1:0]     fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data
`ifdef ALIGN_READER_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic             inflight;
    logic [1:0]       occ;
    logic             credit_ok;

    // A word holds a credit from the cycle after its pop until it leaves the
    // buffer, so two credits bound storage even with the array stalled.
    assign credit_ok = (({1'b0, occ}) + {2'b00, inflight}) < 3'd2;
    assign fifo_re   = (state == ALIGN_RD_RUN) && !fifo_empty &&
                       (issued < len_q) && credit_ok;
    assign busy      = (state == ALIGN_RD_RUN) || (state == ALIGN_RD_DRAIN);
    assign done      = (state == ALIGN_RD_DONE);

    // Burst sequencing: count pops in RUN, wait for the buffer to empty in DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ALIGN_RD_IDLE;
            len_q  <= '0;
            issued <= '0;
        end else begin
            case (state)
                ALIGN_RD_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        issued <= '0;
                        state  <= (len == '0) ? ALIGN_RD_DONE : ALIGN_RD_RUN;
                    end
                end
                ALIGN_RD_RUN: begin
                    if (fifo_re) begin
                        issued <= issued + 1'b1;
                        if (issued == len_q - 1'b1) begin
                            state <= ALIGN_RD_DRAIN;
                        end
                    end
                end
                ALIGN_RD_DRAIN: begin
                    if ((occ == 2'd0) && !inflight) begin
                        state <= ALIGN_RD_DONE;
                    end
                end
                default: begin
                    state <= ALIGN_RD_IDLE;
                end
            endcase
        end
    end

    // Tracks the FIFO's one-cycle registered read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_re;
        end
    end

    align_skid_buf #(
        .W(W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight),
        .wr_data (fifo_dout),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .occ     (occ)
    );

`ifdef ALIGN_READER_STALL_CNT_EN
    // Saturating count of cycles the array holds off a valid word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if ((state == ALIGN_RD_IDLE) && start) begin
            stall_cnt <= 16'd0;
        end else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_align_fifo_reader.sv
// tb/tb_align_fifo_reader.sv - self-checking bench for align_fifo_reader
module tb_align_fifo_reader;

    localparam int W     = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             fifo_empty;
    logic             fifo_re;
    logic [W-1:0]     fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
`ifdef ALIGN_READER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // FIFO model: fmem written by the stimulus, read pointer owned by the pop process
    logic [W-1:0] fmem [0:255];
    int           wr_cnt = 0;
    int           rd_cnt = 0;
    logic         hold_empty = 1'b0;

    // Scoreboard state owned by the compare process
    int           xfer_ptr = 0;
    int           nrecv = 0;
    int           re_cnt = 0;
    int           done_cnt = 0;
    logic [W-1:0] recv [0:127];
    int           recv_cyc [0:127];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    int           stall_model = 0;

    align_fifo_reader #(
        .W(W),
        .LEN_W(LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef ALIGN_READER_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty = hold_empty || (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_re && (wr_cnt != rd_cnt)) begin
            fifo_dout <= fmem[rd_cnt];
            rd_cnt    <= rd_cnt + 1;
        end else begin
            fifo_dout <= '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic preload(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_cnt] = base + W'(i);
            wr_cnt++;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #2;
            if (done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Every cycle: stream order, hold under back-pressure, credit bound, empty-read safety
    always begin : chk_proc
        @(negedge clk);
        #2;
        if (reset) begin
            xfer_ptr    = rd_cnt;
            prev_stall  = 1'b0;
            stall_model = 0;
        end else begin
            check("re_while_empty", 32'(fifo_re && fifo_empty), 32'd0);
            check("undelivered_le2", 32'((rd_cnt - xfer_ptr) <= 2), 32'd1);
            if (!m_valid) check("data_zero_when_invalid", 32'(m_data), 32'd0);
            if (!busy) check("valid_when_not_busy", 32'(m_valid), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                check("xfer_was_popped", 32'(xfer_ptr < rd_cnt), 32'd1);
                check("stream_order", 32'(m_data), 32'(fmem[xfer_ptr]));
                recv[nrecv]     = m_data;
                recv_cyc[nrecv] = cyc;
                nrecv++;
                xfer_ptr++;
            end
            if (fifo_re) re_cnt++;
            if (done) done_cnt++;
`ifdef ALIGN_READER_STALL_CNT_EN
            check("stall_cnt", 32'(stall_cnt), 32'(stall_model));
            if (start && !busy && !done) stall_model = 0;
            else if (m_valid && !m_ready && stall_model < 65535) stall_model++;
`endif
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int re0, d0, n0, s;
        logic [W-1:0] exp_w [0:7];

        // 1: reset and idle with a non-empty FIFO
        reset = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
        preload(8'h01, 5);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fifo_re", 32'(fifo_re), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("idle_fifo_re", 32'(fifo_re), 32'd0);
        end

        // 2: len=5, array always ready
        m_ready = 1'b1;
        re0 = re_cnt; d0 = done_cnt; n0 = nrecv;
        @(negedge clk);
        start = 1'b1; len = 8'd5; s = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2_done_timeout", 40);
        @(negedge clk);
        #2;
        check("t2_busy_after_done", 32'(busy), 32'd0);
        check("t2_re_pulses", 32'(re_cnt - re0), 32'd5);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t2_words", 32'(nrecv - n0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t2_word_value", 32'(recv[n0 + i]), 32'(i + 1));
            check("t2_word_cycle", 32'(recv_cyc[n0 + i]), 32'(s + 2 + i));
        end

        // 3: len=4 with the array stalled for 10 cycles
        preload(8'h01, 4);
        m_ready = 1'b0;
        re0 = re_cnt; n0 = nrecv;
        @(negedge clk);
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        check("t3_re_le2", 32'((re_cnt - re0) <= 2), 32'd1);
        check("t3_hold_valid", 32'(m_valid), 32'd1);
        check("t3_hold_data", 32'(m_data), 32'h01);
        @(negedge clk);
        m_ready = 1'b1;
        wait_done("t3_done_timeout", 40);
        check("t3_re_pulses", 32'(re_cnt - re0), 32'd4);
        check("t3_words", 32'(nrecv - n0), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_word_value", 32'(recv[n0 + i]), 32'(i + 1));

        // 4: len=0, then a start during busy is ignored
        @(negedge clk);
        re0 = re_cnt; d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("t4_done_next", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #2;
        check("t4_done_single", 32'(done), 32'd0);
        check("t4_no_re", 32'(re_cnt - re0), 32'd0);
        preload(8'h11, 3);
        re0 = re_cnt; d0 = done_cnt; n0 = nrecv;
        @(negedge clk);
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b1; len = 8'd9;
        #2;
        check("t4_busy_on_restart", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done("t4_done_timeout", 40);
        @(negedge clk);
        check("t4_re_pulses", 32'(re_cnt - re0), 32'd3);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_words", 32'(nrecv - n0), 32'd3);
        for (int i = 0; i < 3; i++) check("t4_word_value", 32'(recv[n0 + i]), 32'(8'h11 + i));

        // 5: len=7 with fifo_empty toggling every 3 cycles
        preload(8'h21, 7);
        for (int i = 0; i < 7; i++) exp_w[i] = 8'h21 + 8'(i);
        re0 = re_cnt; n0 = nrecv;
        @(negedge clk);
        start = 1'b1; len = 8'd7;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (i % 3 == 2) hold_empty = ~hold_empty;
                #2;
                if (done) seen = 1'b1;
            end
            check("t5_done_timeout", 32'(seen), 32'd1);
        end
        hold_empty = 1'b0;
        check("t5_re_pulses", 32'(re_cnt - re0), 32'd7);
        check("t5_words", 32'(nrecv - n0), 32'd7);
        for (int i = 0; i < 7; i++) check("t5_word_value", 32'(recv[n0 + i]), 32'(exp_w[i]));

        // 6: reset mid-DRAIN with two words buffered, then a fresh burst
        @(negedge clk);
        preload(8'h31, 2);
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        check("t6_busy_drain", 32'(busy), 32'd1);
        check("t6_valid_buffered", 32'(m_valid), 32'd1);
        check("t6_head_data", 32'(m_data), 32'h31);
`ifdef ALIGN_READER_STALL_CNT_EN
        check("t6_stall_cnt_10", 32'(stall_cnt), 32'd10);
`endif
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_m_data", 32'(m_data), 32'd0);
        check("t6_rst_fifo_re", 32'(fifo_re), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_ready = 1'b1;
        preload(8'h41, 2);
        re0 = re_cnt; n0 = nrecv;
        @(negedge clk);
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6_done_timeout", 40);
        check("t6_re_pulses", 32'(re_cnt - re0), 32'd2);
        check("t6_words", 32'(nrecv - n0), 32'd2);
        check("t6_word0", 32'(recv[n0]), 32'h41);
        check("t6_word1", 32'(recv[n0 + 1]), 32'h42);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
